ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
Sequential PS/2 set-2 scancode stream decoder. It consumes raw bytes from the PS/2 receiver one strobe at a time and tracks prefix/break state and modifier state (Shift, Ctrl, Caps Lock). It maps make codes to ASCII and buffers the characters in a parametrised FIFO with a valid/ready output handshake. It sits between the PS/2 byte receiver and the character consumer (UART/console/display).

Parameters:
FIFO_DEPTH, 8, output FIFO entries; power of 2, >=2.
CAPS_EN, 1, 1 = Caps Lock inverts shift for letters only; 0 = Caps ignored.
CTRL_EN, 1, 1 = Ctrl+letter emits control code (letter & 8'h1F); 0 = Ctrl ignored for mapping.
REPEAT_EN, 1, 1 = emit typematic repeats; 0 = emit only first make until that key's break.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
scan_valid  in  1  one-cycle strobe, scan_code valid
scan_code  in  8  raw set-2 byte
ascii_valid  out  1  FIFO non-empty
ascii_code  out  8  head-of-FIFO character (show-ahead)
ascii_ready  in  1  consumer pops head when ascii_valid & ascii_ready
shift_held  out  1  either Shift held
ctrl_held  out  1  either Ctrl held
caps_lock  out  1  Caps Lock toggle state
overflow  out  1  sticky: a character was dropped due to full FIFO
overflow_clr  in  1  clears overflow
fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held

Behaviour:
- One clock; reset is synchronous and active-high. Reset: all outputs 0, FIFO empty, parser IDLE, modifiers cleared, last_make cleared, pause counter 0.
- Parser states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (E0 then F0), PAUSE (skip bytes after E1).
  - IDLE: E0->EXT; F0->BRK; E1->PAUSE with skip counter = 7; FA/AA/EE/FE/00/FF ignored; other byte = make, non-extended.
  - EXT: F0->EXT_BRK; E0/E1 -> treat as in IDLE; other byte = make, extended; ->IDLE.
  - BRK / EXT_BRK: byte = break (extended in EXT_BRK); ->IDLE.
  - PAUSE: decrement per byte; ->IDLE after 7th byte; nothing emitted.
- Modifiers: 12/59 = L/R Shift (separate held bits, shift_held = OR); 14 and E0 14 = L/R Ctrl. Make sets, break clears. 58 make toggles caps_lock only if caps key not already held (repeat-safe); break clears caps-held flag. Modifier keys never push characters.
- Mapping (shared keymap): letters, digits, punctuation, Space, Tab, Enter(5A, E0 5A -> 8'h0D), Bksp(66 -> 8'h08), Esc(76 -> 8'h1B), keypad digits and operators, E0 4A -> "/". Unmapped -> no push.
- Effective shift for letters = shift_held ^ (caps_lock & CAPS_EN); non-letters use shift_held. With CTRL_EN and ctrl_held, letters push lower-case & 8'h1F; Ctrl with non-letter pushes the normal mapping.
- REPEAT_EN=0: make equal to last_make (incl. extended bit) suppressed; break of that key clears last_make.
- Latency: byte accepted at cycle N -> character visible with ascii_valid=1 at N+1. No combinational path from scan_code to ascii_code.
- FIFO: push and pop in the same cycle are both honoured, including when full (push accepted, count unchanged). Push while full and no pop: character dropped, overflow=1. overflow_clr in the same cycle as a new drop: overflow stays 1 (set wins). Pop when empty: ignored.
- Reset mid-sequence (e.g. after F0) abandons the partial sequence. The next byte is parsed from IDLE.

Decomposition:
- Package ps2_pkg: scancode constants (E0, F0, E1, modifier codes, controller response codes), parser state enum, ASCII constants (CR, BS, ESC, TAB).
- Sub-module ps2_keymap: combinational (extended, shift, scan_code) -> (ascii, valid, is_letter). The FIFO is written inline.

Test Plan:
- 1C, F0 1C -> one push 8'h61 "a"; ascii_valid high the cycle after 1C; shift/ctrl/caps stay 0.
- 12, 1C, F0 1C, F0 12, 1C -> pushes "A" then "a"; shift_held 1 between 12 and F0 12.
- 58, F0 58, 1C, 16 -> caps_lock=1, pushes "A", "1"; with 12 also held, 1C -> "a" and 16 -> "!".
- 14, 21 (CTRL_EN=1) -> push 8'h03; E0 4A -> "/"; E1 14 77 E1 F0 14 F0 77 -> nothing pushed, parser back in IDLE.
- FIFO_DEPTH=8, ascii_ready=0, 9 make-codes of 1C -> fifo_count=8, overflow=1, 9th dropped; assert ready with a simultaneous push -> count stays 8; overflow_clr -> overflow=0.
- F0, reset for 1 cycle, then 1C -> "a" pushed (break state discarded); REPEAT_EN=0: 1C,1C,1C,F0 1C,1C -> exactly two "a".

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 set-2 key decoder: scancode prefix and
// modifier constants, keyboard controller response codes, ASCII control
// characters and the parser state enum.
// ---------------------------------------------------------------------------
package ps2_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ECHO   = 8'hEE;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_ERR0   = 8'h00;
   localparam logic [7:0] SC_ERR1   = 8'hFF;

   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_BS  = 8'h08;
   localparam logic [7:0] ASCII_ESC = 8'h1B;
   localparam logic [7:0] ASCII_TAB = 8'h09;

   // Pause/Break sends E1 followed by seven more bytes that carry no key.
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   typedef enum logic [2:0] {
      PS_IDLE,
      PS_EXT,
      PS_BRK,
      PS_EXT_BRK,
      PS_PAUSE
   } parseState_t;

   // Bytes the keyboard sends as controller responses rather than keys.
   function automatic logic isCtrlResponse(input logic [7:0] code);
      return (code == SC_ACK) || (code == SC_BAT) || (code == SC_ECHO) ||
             (code == SC_RESEND) || (code == SC_ERR0) || (code == SC_ERR1);
   endfunction

endpackage

// File: rtl/ps2_keymap.sv
// ---------------------------------------------------------------------------
// ps2_keymap
// Combinational set-2 make code to ASCII lookup.
//   extended_i  : code was preceded by E0
//   shift_i     : select the shifted glyph
//   scan_code_i : make code byte
//   ascii_o     : mapped character (0 when unmapped)
//   valid_o     : code has a mapping
//   is_letter_o : code is one of the 26 letter keys
// Keypad keys and the whitespace/control keys ignore shift.
// ---------------------------------------------------------------------------
module ps2_keymap
   import ps2_pkg::*;
(
   input  logic       extended_i,
   input  logic       shift_i,
   input  logic [7:0] scan_code_i,
   output logic [7:0] ascii_o,
   output logic       valid_o,
   output logic       is_letter_o
);

   logic [7:0] lower;
   logic [7:0] upper;

   // Each entry is {mapped, letter, unshifted, shifted}.
   always_comb begin
      {valid_o, is_letter_o, lower, upper} = 18'd0;
      if (extended_i) begin
         case (scan_code_i)
            8'h4A: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h2F, 8'h2F};
            8'h5A: {valid_o, is_letter_o, lower, upper} = {2'b10, ASCII_CR, ASCII_CR};
            default: ;
         endcase
      end else begin
         case (scan_code_i)
            8'h1C: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h61, 8'h41};
            8'h32: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h62, 8'h42};
            8'h21: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h63, 8'h43};
            8'h23: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h64, 8'h44};
            8'h24: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h65, 8'h45};
            8'h2B: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h66, 8'h46};
            8'h34: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h67, 8'h47};
            8'h33: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h68, 8'h48};
            8'h43: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h69, 8'h49};
            8'h3B: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h6A, 8'h4A};
            8'h42: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h6B, 8'h4B};
            8'h4B: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h6C, 8'h4C};
            8'h3A: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h6D, 8'h4D};
            8'h31: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h6E, 8'h4E};
            8'h44: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h6F, 8'h4F};
            8'h4D: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h70, 8'h50};
            8'h15: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h71, 8'h51};
            8'h2D: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h72, 8'h52};
            8'h1B: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h73, 8'h53};
            8'h2C: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h74, 8'h54};
            8'h3C: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h75, 8'h55};
            8'h2A: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h76, 8'h56};
            8'h1D: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h77, 8'h57};
            8'h22: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h78, 8'h58};
            8'h35: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h79, 8'h59};
            8'h1A: {valid_o, is_letter_o, lower, upper} = {2'b11, 8'h7A, 8'h5A};
            8'h16: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h31, 8'h21};
            8'h1E: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h32, 8'h40};
            8'h26: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h33, 8'h23};
            8'h25: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h34, 8'h24};
            8'h2E: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h35, 8'h25};
            8'h36: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h36, 8'h5E};
            8'h3D: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h37, 8'h26};
            8'h3E: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h38, 8'h2A};
            8'h46: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h39, 8'h28};
            8'h45: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h30, 8'h29};
            8'h0E: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h60, 8'h7E};
            8'h4E: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h2D, 8'h5F};
            8'h55: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h3D, 8'h2B};
            8'h54: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h5B, 8'h7B};
            8'h5B: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h5D, 8'h7D};
            8'h5D: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h5C, 8'h7C};
            8'h4C: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h3B, 8'h3A};
            8'h52: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h27, 8'h22};
            8'h41: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h2C, 8'h3C};
            8'h49: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h2E, 8'h3E};
            8'h4A: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h2F, 8'h3F};
            8'h29: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h20, 8'h20};
            8'h0D: {valid_o, is_letter_o, lower, upper} = {2'b10, ASCII_TAB, ASCII_TAB};
            8'h5A: {valid_o, is_letter_o, lower, upper} = {2'b10, ASCII_CR, ASCII_CR};
            8'h66: {valid_o, is_letter_o, lower, upper} = {2'b10, ASCII_BS, ASCII_BS};
            8'h76: {valid_o, is_letter_o, lower, upper} = {2'b10, ASCII_ESC, ASCII_ESC};
            8'h70: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h30, 8'h30};
            8'h69: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h31, 8'h31};
            8'h72: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h32, 8'h32};
            8'h7A: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h33, 8'h33};
            8'h6B: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h34, 8'h34};
            8'h73: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h35, 8'h35};
            8'h74: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h36, 8'h36};
            8'h6C: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h37, 8'h37};
            8'h75: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h38, 8'h38};
            8'h7D: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h39, 8'h39};
            8'h71: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h2E, 8'h2E};
            8'h7C: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h2A, 8'h2A};
            8'h7B: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h2D, 8'h2D};
            8'h79: {valid_o, is_letter_o, lower, upper} = {2'b10, 8'h2B, 8'h2B};
            default: ;
         endcase
      end
   end

   assign ascii_o = shift_i ? upper : lower;

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Turns a stream of raw PS/2 set-2 bytes into ASCII characters held in an
// output FIFO.
//   clk, reset          : clock and synchronous active-high reset
//   scan_valid/scan_code: one-cycle strobe with a raw scancode byte
//   ascii_valid/code    : FIFO non-empty and show-ahead head character
//   ascii_ready         : consumer pops the head when valid & ready
//   shift_held/ctrl_held/caps_lock : modifier state
//   overflow/overflow_clr : sticky dropped-character flag and its clear
//   fifo_count          : number of characters buffered
// ---------------------------------------------------------------------------
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CAPS_EN    = 1,
   parameter int CTRL_EN    = 1,
   parameter int REPEAT_EN  = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            scan_valid,
   input  logic [7:0]                      scan_code,
   output logic                            ascii_valid,
   output logic [7:0]                      ascii_code,
   input  logic                            ascii_ready,
   output logic                            shift_held,
   output logic                            ctrl_held,
   output logic                            caps_lock,
   output logic                            overflow,
   input  logic                            overflow_clr,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   parseState_t state_q, state_d;
   logic [2:0]  pauseCnt_q, pauseCnt_d;
   logic        shiftL_q, shiftL_d, shiftR_q, shiftR_d;
   logic        ctrlL_q, ctrlL_d, ctrlR_q, ctrlR_d;
   logic        caps_q, caps_d, capsHeld_q, capsHeld_d;
   logic [8:0]  lastMake_q, lastMake_d;
   logic        lastValid_q, lastValid_d;
   logic        overflow_q, overflow_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [7:0]  mem_q [FIFO_DEPTH];

   logic       mapExt, mapValid, mapLetter;
   logic [7:0] mapAscii;
   logic [8:0] keyId;
   logic       evMake, evBreak, isModifier, repeatHit;
   logic       pushEn, pushOk, pop, full, drop;
   logic [7:0] pushData;

   assign mapExt = (state_q == PS_EXT) || (state_q == PS_EXT_BRK);
   assign keyId  = {mapExt, scan_code};

   ps2_keymap u_keymap (
      .extended_i  (mapExt),
      .shift_i     (shift_held),
      .scan_code_i (scan_code),
      .ascii_o     (mapAscii),
      .valid_o     (mapValid),
      .is_letter_o (mapLetter)
   );

   // Parser next state plus make/break classification of the current byte.
   // Controller responses are only filtered straight out of IDLE; after E0
   // everything that is not a prefix counts as an extended make.
   always_comb begin
      state_d    = state_q;
      pauseCnt_d = pauseCnt_q;
      evMake     = 1'b0;
      evBreak    = 1'b0;
      if (scan_valid) begin
         unique case (state_q)
            PS_IDLE, PS_EXT: begin
               if (scan_code == SC_BRK) begin
                  state_d = (state_q == PS_EXT) ? PS_EXT_BRK : PS_BRK;
               end else if (scan_code == SC_EXT) begin
                  state_d = PS_EXT;
               end else if (scan_code == SC_PAUSE) begin
                  state_d    = PS_PAUSE;
                  pauseCnt_d = PAUSE_SKIP;
               end else if ((state_q == PS_IDLE) && isCtrlResponse(scan_code)) begin
                  state_d = PS_IDLE;
               end else begin
                  evMake  = 1'b1;
                  state_d = PS_IDLE;
               end
            end
            PS_BRK, PS_EXT_BRK: begin
               evBreak = 1'b1;
               state_d = PS_IDLE;
            end
            PS_PAUSE: begin
               pauseCnt_d = pauseCnt_q - 3'd1;
               if (pauseCnt_q == 3'd1) begin
                  state_d = PS_IDLE;
               end
            end
            default: state_d = PS_IDLE;
         endcase
      end
   end

   // Modifier tracking, repeat suppression and character generation. Caps
   // is folded in by flipping the case bit of letters, and Ctrl+letter
   // keeps only the low five bits, which is the same for either case.
   always_comb begin
      shiftL_d    = shiftL_q;
      shiftR_d    = shiftR_q;
      ctrlL_d     = ctrlL_q;
      ctrlR_d     = ctrlR_q;
      caps_d      = caps_q;
      capsHeld_d  = capsHeld_q;
      lastMake_d  = lastMake_q;
      lastValid_d = lastValid_q;
      pushEn      = 1'b0;
      pushData    = mapAscii;
      isModifier  = (keyId == {1'b0, SC_LSHIFT}) || (keyId == {1'b0, SC_RSHIFT}) ||
                    (scan_code == SC_CTRL) || (keyId == {1'b0, SC_CAPS});
      repeatHit   = (REPEAT_EN == 0) && lastValid_q && (lastMake_q == keyId);

      if (mapLetter && (CAPS_EN != 0) && caps_q) begin
         pushData = mapAscii ^ 8'h20;
      end
      if (mapLetter && (CTRL_EN != 0) && ctrl_held) begin
         pushData = mapAscii & 8'h1F;
      end

      if (evMake) begin
         if (keyId == {1'b0, SC_LSHIFT}) shiftL_d = 1'b1;
         if (keyId == {1'b0, SC_RSHIFT}) shiftR_d = 1'b1;
         if (keyId == {1'b0, SC_CTRL})   ctrlL_d  = 1'b1;
         if (keyId == {1'b1, SC_CTRL})   ctrlR_d  = 1'b1;
         if (keyId == {1'b0, SC_CAPS}) begin
            capsHeld_d = 1'b1;
            if (!capsHeld_q) caps_d = ~caps_q;
         end
         if (!isModifier && !repeatHit) begin
            lastMake_d  = keyId;
            lastValid_d = 1'b1;
            pushEn      = mapValid;
         end
      end

      if (evBreak) begin
         if (keyId == {1'b0, SC_LSHIFT}) shiftL_d   = 1'b0;
         if (keyId == {1'b0, SC_RSHIFT}) shiftR_d   = 1'b0;
         if (keyId == {1'b0, SC_CTRL})   ctrlL_d    = 1'b0;
         if (keyId == {1'b1, SC_CTRL})   ctrlR_d    = 1'b0;
         if (keyId == {1'b0, SC_CAPS})   capsHeld_d = 1'b0;
         if (lastValid_q && (lastMake_q == keyId)) lastValid_d = 1'b0;
      end
   end

   // FIFO bookkeeping. A pop frees the slot being written, so a push into a
   // full FIFO is still accepted when the consumer pops in the same cycle.
   always_comb begin
      pop        = ascii_ready && (count_q != '0);
      full       = (count_q == CW'(FIFO_DEPTH));
      pushOk     = pushEn && (!full || pop);
      drop       = pushEn && full && !pop;
      count_d    = count_q + CW'(pushOk) - CW'(pop);
      wrPtr_d    = wrPtr_q + AW'(pushOk);
      rdPtr_d    = rdPtr_q + AW'(pop);
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end
   end

   // State registers, all cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= PS_IDLE;
         pauseCnt_q  <= '0;
         shiftL_q    <= 1'b0;
         shiftR_q    <= 1'b0;
         ctrlL_q     <= 1'b0;
         ctrlR_q     <= 1'b0;
         caps_q      <= 1'b0;
         capsHeld_q  <= 1'b0;
         lastMake_q  <= '0;
         lastValid_q <= 1'b0;
         overflow_q  <= 1'b0;
         count_q     <= '0;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
      end else begin
         state_q     <= state_d;
         pauseCnt_q  <= pauseCnt_d;
         shiftL_q    <= shiftL_d;
         shiftR_q    <= shiftR_d;
         ctrlL_q     <= ctrlL_d;
         ctrlR_q     <= ctrlR_d;
         caps_q      <= caps_d;
         capsHeld_q  <= capsHeld_d;
         lastMake_q  <= lastMake_d;
         lastValid_q <= lastValid_d;
         overflow_q  <= overflow_d;
         count_q     <= count_d;
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
      end
   end

   // Character storage needs no reset; the head output is masked while
   // the FIFO is empty.
   always_ff @(posedge clk) begin
      if (pushOk && !reset) begin
         mem_q[wrPtr_q] <= pushData;
      end
   end

   assign ascii_valid = (count_q != '0);
   assign ascii_code  = ascii_valid ? mem_q[rdPtr_q] : 8'h00;
   assign shift_held  = shiftL_q | shiftR_q;
   assign ctrl_held   = ctrlL_q | ctrlR_q;
   assign caps_lock   = caps_q;
   assign overflow    = overflow_q;
   assign fifo_count  = count_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
// Self-checking bench for ps2_key_decoder: a table of byte/expectation
// vectors, hand-written FIFO, reset and repeat sequences, and a random
// stream compared against a keyboard-level reference model.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       reset, scanValid, asciiReady, overflowClr;
   logic [7:0] scanCode;
   logic       asciiValid, shiftHeld, ctrlHeld, capsLock, overflowFlag;
   logic [7:0] asciiCode;
   logic [3:0] fifoCount;

   logic       nrReset, nrScanValid, nrAsciiReady, nrOverflowClr;
   logic [7:0] nrScanCode;
   logic       nrAsciiValid, nrShift, nrCtrl, nrCaps, nrOverflow;
   logic [7:0] nrAsciiCode;
   logic [3:0] nrCount;

   int checks = 0;
   int errors = 0;

   // Free-running 10-unit clock shared by both decoders.
   always #5 clk = ~clk;

   ps2_key_decoder #(.FIFO_DEPTH(8), .CAPS_EN(1), .CTRL_EN(1), .REPEAT_EN(1)) dut (
      .clk(clk), .reset(reset), .scan_valid(scanValid), .scan_code(scanCode),
      .ascii_valid(asciiValid), .ascii_code(asciiCode), .ascii_ready(asciiReady),
      .shift_held(shiftHeld), .ctrl_held(ctrlHeld), .caps_lock(capsLock),
      .overflow(overflowFlag), .overflow_clr(overflowClr), .fifo_count(fifoCount)
   );

   ps2_key_decoder #(.FIFO_DEPTH(8), .CAPS_EN(1), .CTRL_EN(1), .REPEAT_EN(0)) dutNr (
      .clk(clk), .reset(nrReset), .scan_valid(nrScanValid), .scan_code(nrScanCode),
      .ascii_valid(nrAsciiValid), .ascii_code(nrAsciiCode), .ascii_ready(nrAsciiReady),
      .shift_held(nrShift), .ctrl_held(nrCtrl), .caps_lock(nrCaps),
      .overflow(nrOverflow), .overflow_clr(nrOverflowClr), .fifo_count(nrCount)
   );

   // Reference model: keyboard-level view of pending prefixes, held keys
   // and a character queue.
   logic [7:0] loMap [256];
   logic [7:0] hiMap [256];
   bit         known [256];
   bit         mPendExt, mPendBrk, mShL, mShR, mCtL, mCtR, mCaps, mCapsDown, mOvf;
   int         mSkip;
   logic [7:0] mQ [$];

   typedef struct {
      logic [7:0] code;
      logic       expValid;
      logic [7:0] expCode;
      logic       expShift;
      logic       expCtrl;
      logic       expCaps;
   } vec_t;
   vec_t vecs [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic addKey(input logic [7:0] code, input logic [7:0] lo, input logic [7:0] hi);
      known[code] = 1'b1;
      loMap[code] = lo;
      hiMap[code] = hi;
   endtask

   task automatic addLetters();
      logic [7:0] codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
      for (int i = 0; i < 26; i++) addKey(codes[i], 8'(8'h61 + i), 8'(8'h41 + i));
   endtask

   task automatic buildMaps();
      for (int i = 0; i < 256; i++) begin
         known[i] = 1'b0; loMap[i] = 8'h00; hiMap[i] = 8'h00;
      end
      addLetters();
      addKey(8'h16, "1", "!"); addKey(8'h1E, "2", "@"); addKey(8'h26, "3", "#");
      addKey(8'h25, "4", "$"); addKey(8'h2E, "5", "%"); addKey(8'h36, "6", "^");
      addKey(8'h3D, "7", "&"); addKey(8'h3E, "8", "*"); addKey(8'h46, "9", "(");
      addKey(8'h45, "0", ")"); addKey(8'h0E, 8'h60, "~"); addKey(8'h4E, "-", "_");
      addKey(8'h55, "=", "+"); addKey(8'h54, "[", "{"); addKey(8'h5B, "]", "}");
      addKey(8'h5D, 8'h5C, "|"); addKey(8'h4C, ";", ":"); addKey(8'h52, "'", 8'h22);
      addKey(8'h41, ",", "<"); addKey(8'h49, ".", ">"); addKey(8'h4A, "/", "?");
      addKey(8'h29, " ", " "); addKey(8'h0D, 8'h09, 8'h09); addKey(8'h5A, 8'h0D, 8'h0D);
      addKey(8'h66, 8'h08, 8'h08); addKey(8'h76, 8'h1B, 8'h1B);
      addKey(8'h70, "0", "0"); addKey(8'h69, "1", "1"); addKey(8'h72, "2", "2");
      addKey(8'h7A, "3", "3"); addKey(8'h6B, "4", "4"); addKey(8'h73, "5", "5");
      addKey(8'h74, "6", "6"); addKey(8'h6C, "7", "7"); addKey(8'h75, "8", "8");
      addKey(8'h7D, "9", "9"); addKey(8'h71, ".", "."); addKey(8'h7C, "*", "*");
      addKey(8'h7B, "-", "-"); addKey(8'h79, "+", "+");
   endtask

   task automatic modelReset();
      mPendExt = 0; mPendBrk = 0; mSkip = 0;
      mShL = 0; mShR = 0; mCtL = 0; mCtR = 0; mCaps = 0; mCapsDown = 0; mOvf = 0;
      mQ.delete();
   endtask

   // Which character, if any, a key press produces given the held keys.
   task automatic keyPress(input bit ext, input logic [7:0] code, output bit have, output logic [7:0] ch);
      bit letter, upperCase;
      have = 0; ch = 8'h00;
      if (!ext && code == 8'h12) mShL = 1;
      else if (!ext && code == 8'h59) mShR = 1;
      else if (code == 8'h14) begin if (ext) mCtR = 1; else mCtL = 1; end
      else if (!ext && code == 8'h58) begin
         if (!mCapsDown) mCaps = !mCaps;
         mCapsDown = 1;
      end else if (ext) begin
         if (code == 8'h4A) begin have = 1; ch = "/"; end
         if (code == 8'h5A) begin have = 1; ch = 8'h0D; end
      end else if (known[code]) begin
         have = 1;
         letter = (loMap[code] >= "a") && (loMap[code] <= "z");
         upperCase = (mShL || mShR) ^ (letter && mCaps);
         ch = upperCase ? hiMap[code] : loMap[code];
         if (letter && (mCtL || mCtR)) ch = loMap[code] - 8'h60;
      end
   endtask

   task automatic keyRelease(input bit ext, input logic [7:0] code);
      if (!ext && code == 8'h12) mShL = 0;
      if (!ext && code == 8'h59) mShR = 0;
      if (code == 8'h14) begin if (ext) mCtR = 0; else mCtL = 0; end
      if (!ext && code == 8'h58) mCapsDown = 0;
   endtask

   task automatic modelStep(input bit valid, input logic [7:0] code, input bit ready, input bit clr);
      bit have, dropped, ignored;
      logic [7:0] ch;
      have = 0; dropped = 0; ch = 8'h00;
      ignored = (code == 8'hFA) || (code == 8'hAA) || (code == 8'hEE) ||
                (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
      if (valid) begin
         if (mSkip > 0) mSkip--;
         else if (mPendBrk) begin keyRelease(mPendExt, code); mPendBrk = 0; mPendExt = 0; end
         else if (code == 8'hF0) mPendBrk = 1;
         else if (code == 8'hE0) mPendExt = 1;
         else if (code == 8'hE1) begin mSkip = 7; mPendExt = 0; end
         else if (!mPendExt && ignored) ;
         else begin keyPress(mPendExt, code, have, ch); mPendExt = 0; end
      end
      if (ready && mQ.size() > 0) void'(mQ.pop_front());
      if (have) begin
         if (mQ.size() < 8) mQ.push_back(ch);
         else dropped = 1;
      end
      if (dropped) mOvf = 1;
      else if (clr) mOvf = 0;
   endtask

   task automatic applyStimulus(input bit valid, input logic [7:0] code, input bit ready, input bit clr);
      scanValid = valid; scanCode = code; asciiReady = ready; overflowClr = clr;
      @(posedge clk);
      if (reset) modelReset();
      else modelStep(valid, code, ready, clr);
      #1;
      scanValid = 0; asciiReady = 0; overflowClr = 0;
   endtask

   task automatic checkOutput(input string tag);
      check({tag, ".valid"}, asciiValid, mQ.size() > 0);
      if (mQ.size() > 0) check({tag, ".code"}, asciiCode, mQ[0]);
      check({tag, ".count"}, fifoCount, mQ.size());
      check({tag, ".shift"}, shiftHeld, mShL || mShR);
      check({tag, ".ctrl"}, ctrlHeld, mCtL || mCtR);
      check({tag, ".caps"}, capsLock, mCaps);
      check({tag, ".ovf"}, overflowFlag, mOvf);
   endtask

   task automatic doReset();
      reset = 1;
      applyStimulus(0, 8'h00, 0, 0);
      reset = 0;
   endtask

   task automatic nrTick(input bit valid, input logic [7:0] code, input bit ready);
      nrScanValid = valid; nrScanCode = code; nrAsciiReady = ready;
      @(posedge clk); #1;
      nrScanValid = 0; nrAsciiReady = 0;
   endtask

   task automatic addVec(input logic [7:0] c, input logic v, input logic [7:0] a,
                         input logic s, input logic ct, input logic k);
      vecs.push_back('{c, v, a, s, ct, k});
   endtask

   // Stimulus sequencer: table, corner sequences, random stream, summary.
   initial begin
      logic [7:0] pool [$] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h1E, 8'h4E, 8'h29, 8'h5A,
                               8'h66, 8'h76, 8'h70, 8'h7C, 8'h4A, 8'h12, 8'h59, 8'h14,
                               8'h58, 8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'hE1, 8'hFA, 8'hAA,
                               8'h00, 8'h07};
      reset = 0; scanValid = 0; scanCode = 0; asciiReady = 0; overflowClr = 0;
      nrReset = 0; nrScanValid = 0; nrScanCode = 0; nrAsciiReady = 0; nrOverflowClr = 0;
      buildMaps();
      modelReset();

      doReset();
      checkOutput("reset");

      addVec(8'h1C, 1, 8'h61, 0, 0, 0); addVec(8'hF0, 0, 8'h00, 0, 0, 0);
      addVec(8'h1C, 0, 8'h00, 0, 0, 0); addVec(8'h12, 0, 8'h00, 1, 0, 0);
      addVec(8'h1C, 1, 8'h41, 1, 0, 0); addVec(8'hF0, 0, 8'h00, 1, 0, 0);
      addVec(8'h1C, 0, 8'h00, 1, 0, 0); addVec(8'hF0, 0, 8'h00, 1, 0, 0);
      addVec(8'h12, 0, 8'h00, 0, 0, 0); addVec(8'h1C, 1, 8'h61, 0, 0, 0);
      addVec(8'h58, 0, 8'h00, 0, 0, 1); addVec(8'hF0, 0, 8'h00, 0, 0, 1);
      addVec(8'h58, 0, 8'h00, 0, 0, 1); addVec(8'h1C, 1, 8'h41, 0, 0, 1);
      addVec(8'h16, 1, 8'h31, 0, 0, 1); addVec(8'h12, 0, 8'h00, 1, 0, 1);
      addVec(8'h1C, 1, 8'h61, 1, 0, 1); addVec(8'h16, 1, 8'h21, 1, 0, 1);
      addVec(8'hF0, 0, 8'h00, 1, 0, 1); addVec(8'h12, 0, 8'h00, 0, 0, 1);
      addVec(8'h58, 0, 8'h00, 0, 0, 0); addVec(8'hF0, 0, 8'h00, 0, 0, 0);
      addVec(8'h58, 0, 8'h00, 0, 0, 0); addVec(8'h14, 0, 8'h00, 0, 1, 0);
      addVec(8'h21, 1, 8'h03, 0, 1, 0); addVec(8'hF0, 0, 8'h00, 0, 1, 0);
      addVec(8'h14, 0, 8'h00, 0, 0, 0); addVec(8'hE0, 0, 8'h00, 0, 0, 0);
      addVec(8'h4A, 1, 8'h2F, 0, 0, 0); addVec(8'hE0, 0, 8'h00, 0, 0, 0);
      addVec(8'h5A, 1, 8'h0D, 0, 0, 0); addVec(8'h66, 1, 8'h08, 0, 0, 0);
      addVec(8'hE1, 0, 8'h00, 0, 0, 0); addVec(8'h14, 0, 8'h00, 0, 0, 0);
      addVec(8'h77, 0, 8'h00, 0, 0, 0); addVec(8'hE1, 0, 8'h00, 0, 0, 0);
      addVec(8'hF0, 0, 8'h00, 0, 0, 0); addVec(8'h14, 0, 8'h00, 0, 0, 0);
      addVec(8'hF0, 0, 8'h00, 0, 0, 0); addVec(8'h77, 0, 8'h00, 0, 0, 0);
      addVec(8'h1C, 1, 8'h61, 0, 0, 0); addVec(8'hF0, 0, 8'h00, 0, 0, 0);
      addVec(8'h1C, 0, 8'h00, 0, 0, 0);
      foreach (vecs[i]) begin
         applyStimulus(1, vecs[i].code, 1, 0);
         check($sformatf("vec%0d.valid", i), asciiValid, vecs[i].expValid);
         if (vecs[i].expValid) check($sformatf("vec%0d.code", i), asciiCode, vecs[i].expCode);
         check($sformatf("vec%0d.shift", i), shiftHeld, vecs[i].expShift);
         check($sformatf("vec%0d.ctrl", i), ctrlHeld, vecs[i].expCtrl);
         check($sformatf("vec%0d.caps", i), capsLock, vecs[i].expCaps);
      end

      doReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1, 8'h1C, 0, 0);
         checkOutput("fill");
      end
      check("fullCount", fifoCount, 8);
      check("fullOvf", overflowFlag, 1);
      applyStimulus(1, 8'h1C, 1, 0);
      check("pushPopFullCount", fifoCount, 8);
      check("pushPopFullOvf", overflowFlag, 1);
      applyStimulus(1, 8'h1C, 0, 1);
      check("setWinsOvf", overflowFlag, 1);
      applyStimulus(0, 8'h00, 0, 1);
      check("clrOvf", overflowFlag, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 8'h00, 1, 0);
         checkOutput("drain");
      end
      check("emptyCount", fifoCount, 0);

      doReset();
      applyStimulus(1, 8'hF0, 0, 0);
      doReset();
      applyStimulus(1, 8'h1C, 0, 0);
      check("midResetValid", asciiValid, 1);
      check("midResetCode", asciiCode, 8'h61);
      checkOutput("midReset");

      nrReset = 1; nrTick(0, 8'h00, 0); nrReset = 0;
      nrTick(1, 8'h1C, 0); nrTick(1, 8'h1C, 0); nrTick(1, 8'h1C, 0);
      nrTick(1, 8'hF0, 0); nrTick(1, 8'h1C, 0); nrTick(1, 8'h1C, 0);
      check("noRepeatCount", nrCount, 2);
      check("noRepeatHead0", nrAsciiCode, 8'h61);
      nrTick(0, 8'h00, 1);
      check("noRepeatHead1", nrAsciiCode, 8'h61);
      check("noRepeatCount1", nrCount, 1);
      nrTick(0, 8'h00, 1);
      check("noRepeatEmpty", nrAsciiValid, 0);

      doReset();
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 99) < 60, pool[$urandom_range(0, pool.size() - 1)],
                       $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
         checkOutput("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
